// File: rtl/coeff_update_sequencer.sv
// Stages one set of NUM_CH complex weights from a stream into a shadow file, then bursts
// the set into the inactive coefficient bank right after a bank swap (or at once in immediate mode).
//
// state     | meaning
// COLLECT   | accepting stream words into the shadow file
// WAIT_SWAP | full set staged, waiting for the next bank swap
// WRITE     | bursting shadow[0..NUM_CH-1] to the bank port
// DRAIN     | malformed set, discarding words up to s_last
module coeff_update_sequencer #(
  parameter int NUM_CH      = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst_n,
  input  logic [2*COEFF_WIDTH-1:0] s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic                     cfg_immediate,
  input  logic                     err_clr,
  input  logic                     active_bank,
  output logic [ADDR_WIDTH-1:0]    axi_addr,
  output logic [2*COEFF_WIDTH-1:0] axi_data_w,
  output logic                     axi_we,
  input  logic                     axi_ack,
  output logic                     busy,
  output logic                     set_done,
  output logic                     err_frame,
  output logic                     err_overrun,
  output logic [15:0]              sets_written,
  output logic [1:0]               state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CH - 1);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    WAIT_SWAP = 2'd1,
    WRITE     = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2*COEFF_WIDTH-1:0] shadow [NUM_CH];
  logic [ADDR_WIDTH-1:0]    idx, widx, widx_inc;
  logic [1:0]               sync;
  logic                     prev;
  logic                     swap_evt, collect_beat, frame_err, burst_done;

  assign swap_evt     = sync[1] ^ prev;
  assign collect_beat = s_valid & (state == COLLECT);
  assign frame_err    = collect_beat & (s_last != (idx == LAST_IDX));
  assign burst_done   = (state == WRITE) & axi_we & axi_ack & (widx == LAST_IDX);
  assign widx_inc     = widx + 1'b1;
  assign busy         = (state != COLLECT);
  assign state_dbg    = state;

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) state <= COLLECT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = axi_rst_n;
        if (s_valid && idx == LAST_IDX)
          state_nxt = !s_last ? DRAIN : (cfg_immediate ? WRITE : WAIT_SWAP);
      end
      DRAIN: begin
        s_ready = axi_rst_n;
        if (s_valid && s_last) state_nxt = COLLECT;
      end
      WAIT_SWAP: if (swap_evt) state_nxt = WRITE;
      WRITE:     if (burst_done) state_nxt = COLLECT;
      default:   state_nxt = COLLECT;
    endcase
  end

  // Shadow contents are don't-care after reset, so no reset term here.
  always_ff @(posedge axi_clk) begin
    if (collect_beat) shadow[idx] <= s_data;
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      sync         <= '0;
      prev         <= 1'b0;
      idx          <= '0;
      widx         <= '0;
      axi_we       <= 1'b0;
      axi_addr     <= '0;
      axi_data_w   <= '0;
      set_done     <= 1'b0;
      err_frame    <= 1'b0;
      err_overrun  <= 1'b0;
      sets_written <= '0;
    end else begin
      sync     <= {sync[0], active_bank};
      prev     <= sync[1];
      set_done <= 1'b0;

      if (collect_beat)
        idx <= (s_last || idx == LAST_IDX) ? '0 : idx + 1'b1;

      // A set event beats a simultaneous clear.
      err_frame   <= frame_err | (err_frame & ~err_clr);
      err_overrun <= ((state == WRITE) & swap_evt) | (err_overrun & ~err_clr);

      if (state == WRITE) begin
        if (!axi_we) begin
          axi_we     <= 1'b1;
          axi_addr   <= widx;
          axi_data_w <= shadow[widx];
        end else if (axi_ack) begin
          if (widx == LAST_IDX) begin
            axi_we       <= 1'b0;
            widx         <= '0;
            set_done     <= 1'b1;
            sets_written <= sets_written + 1'b1;
          end else begin
            widx       <= widx_inc;
            axi_addr   <= widx_inc;
            axi_data_w <= shadow[widx_inc];
          end
        end
      end
    end
  end

endmodule
